div_seq_n: RTL and testbench

Parametrised multi-cycle restoring divider for the datapath DIV unit. It computes quotient and remainder of a WIDTH-bit dividend and divisor over WIDTH+2 clock cycles. Signed and unsigned modes are supported, and division-by-zero and overflow are flagged. It uses a start/busy/done handshake so the control unit can stall on it instead of waiting on a long combinational path.

---
 rtl/div_seq_n.sv | 129 ++++++++++++
 tb/tb_div_seq_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_n.sv
// Multi-cycle restoring divider producing {remainder, quotient} over WIDTH+2 cycles.
// Signed and unsigned modes; division-by-zero and signed overflow are flagged.
module div_seq_n #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero,
    output logic                 overflow
);
    // state | meaning
    // IDLE  | waiting for start, operands latched on accept
    // RUN   | one restoring iteration per cycle, MSB first
    // FIX   | sign correction, result and flag load
    // DONE  | done pulse, return to IDLE
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] dvd_r;
    logic             neg_q;
    logic             neg_r;
    logic             dz_r;
    logic             ovf_r;

    logic [WIDTH:0]   a_sh;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // The most negative value maps onto itself, read back as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic s);
        return (s && x[WIDTH-1]) ? (~x + ONE) : x;
    endfunction

    // q doubles as the dividend shift register: its MSB feeds a, quotient bits enter at the LSB.
    assign a_sh  = {a, q[WIDTH-1]};
    assign diff  = a_sh - {1'b0, b};
    assign q_fix = neg_q ? (~q + ONE) : q;
    assign r_fix = neg_r ? (~a + ONE) : a;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state       <= IDLE;
            count       <= '0;
            a           <= '0;
            q           <= '0;
            b           <= '0;
            dvd_r       <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_r        <= 1'b0;
            ovf_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        a     <= '0;
                        q     <= mag(dividend, signed_mode);
                        b     <= mag(divisor, signed_mode);
                        dvd_r <= dividend;
                        neg_q <= signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_mode & dividend[WIDTH-1];
                        dz_r  <= (divisor == '0);
                        ovf_r <= signed_mode && (dividend == MIN_VAL) && (divisor == '1);
                        count <= CNT_INIT;
                        state <= (divisor == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (diff[WIDTH]) begin
                        a <= a_sh[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b0};
                    end else begin
                        a <= diff[WIDTH-1:0];
                        q <= {q[WIDTH-2:0], 1'b1};
                    end
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end
                FIX: begin
                    if (dz_r) begin
                        result <= {dvd_r, {WIDTH{1'b1}}};
                    end else begin
                        result <= {r_fix, q_fix};
                    end
                    div_by_zero <= dz_r;
                    overflow    <= ovf_r;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_n.sv
// Self-checking bench for div_seq_n (WIDTH=32): directed cases, random operands,
// re-pulsed start, back-to-back starts and mid-run clear, against an arithmetic model.
module tb_div_seq_n;
    localparam int W = 32;

    logic           clock;
    logic           clear_n;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   dividend;
    logic [W-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div_by_zero;
    logic           overflow;

    int checks = 0;
    int errors = 0;

    div_seq_n #(.WIDTH(W)) dut (
        .clock       (clock),
        .clear_n     (clear_n),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; SystemVerilog / and % truncate toward zero.
    task automatic model(input logic sm, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic edz, output logic eov);
        longint sd, sv, q64, r64;
        edz = 1'b0;
        eov = 1'b0;
        if (dvs == 0) begin
            eq  = '1;
            er  = dvd;
            edz = 1'b1;
        end else if (sm) begin
            sd  = longint'($signed(dvd));
            sv  = longint'($signed(dvs));
            q64 = sd / sv;
            r64 = sd % sv;
            eq  = q64[W-1:0];
            er  = r64[W-1:0];
            eov = (dvd == 32'h8000_0000) && (dvs == 32'hFFFF_FFFF);
        end else begin
            eq = dvd / dvs;
            er = dvd % dvs;
        end
    endtask

    task automatic do_op(input logic sm, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                         input int repulse, input bit hold);
        logic [W-1:0] eq, er;
        logic         edz, eov;
        int           n;
        bit           seen;
        model(sm, dvd, dvs, eq, er, edz, eov);
        signed_mode = sm;
        dividend    = dvd;
        divisor     = dvs;
        start       = 1'b1;
        tick();
        n = 1;
        if (!hold) start = 1'b0;
        seen = 0;
        while (n < 60 && !seen) begin
            if (done) begin
                seen = 1;
            end else begin
                check($sformatf("busy_c%0d", n), busy, 1);
                if (!hold) begin
                    dividend    = $urandom;
                    divisor     = $urandom;
                    signed_mode = 1'($urandom_range(0, 1));
                    start       = (n == repulse);
                end
                tick();
                n++;
            end
        end
        check("done_seen", seen, 1);
        check("latency", n, edz ? 2 : W + 2);
        check("quotient", result[W-1:0], eq);
        check("remainder", result[2*W-1:W], er);
        check("div_by_zero", div_by_zero, edz);
        check("overflow", overflow, eov);
        check("busy_at_done", busy, 0);
        tick();
        check("done_pulse", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        logic [W-1:0] rd, rv;
        logic         rs;
        bit           seen_done;

        clear_n     = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #1;
        check("rst_result", result, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        tick();
        tick();
        clear_n = 1'b1;
        tick();

        do_op(1'b0, 32'd100, 32'd7, 0, 0);
        do_op(1'b1, -32'sd100, 32'd7, 0, 0);
        do_op(1'b1, 32'd100, -32'sd7, 0, 0);
        do_op(1'b1, -32'sd100, -32'sd7, 0, 0);
        do_op(1'b0, 32'd5, 32'd0, 0, 0);
        do_op(1'b0, 32'd9, 32'd3, 0, 0);
        do_op(1'b1, 32'd5, 32'd0, 0, 0);
        do_op(1'b1, 32'd9, 32'd3, 0, 0);
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        do_op(1'b1, 32'h8000_0000, 32'd1, 0, 0);
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0);

        // start re-pulsed mid-operation with fresh operands must be ignored
        do_op(1'b0, 32'd123456, 32'd789, 10, 0);

        // start held through DONE: next accept only once IDLE is reached
        do_op(1'b0, 32'd100, 32'd7, 0, 1);
        do_op(1'b1, -32'sd55, 32'd4, 0, 0);

        // clear mid-run: everything zero at once, no done afterwards
        signed_mode = 1'b0;
        dividend    = 32'd1000;
        divisor     = 32'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        clear_n = 1'b0;
        #1;
        check("clr_result", result, 0);
        check("clr_busy", busy, 0);
        check("clr_done", done, 0);
        check("clr_dz", div_by_zero, 0);
        check("clr_ovf", overflow, 0);
        repeat (3) tick();
        clear_n   = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        check("no_done_after_clear", seen_done, 0);
        do_op(1'b0, 32'd1000, 32'd3, 0, 0);

        for (int k = 0; k < 25; k++) begin
            rs = 1'($urandom_range(0, 1));
            rd = $urandom;
            case ($urandom_range(0, 9))
                0:       rv = '0;
                1:       rv = $urandom_range(1, 15);
                2: begin rv = '1; if ($urandom_range(0, 1) == 1) rd = 32'h8000_0000; end
                3:       rv = rd >> $urandom_range(0, 31);
                default: rv = $urandom;
            endcase
            do_op(rs, rd, rv, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
